dec_nx2n_seq_chk: RTL and testbench

//  Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake.

---
 rtl/dec_nx2n_seq_chk.sv | 120 ++++++++++++
 tb/tb_dec_nx2n_seq_chk.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dec_nx2n_seq_chk.sv
// Registered N-to-2^N one-hot decoder with valid/ready input, self-test sweep FSM and one-hot checker.
// Latency 1 cycle; in_ready drops during reset, sweep/done, and on a sweep_start cycle. Optional FAULT_INJECT_EN.
module dec_nx2n_seq_chk #(
  parameter int N          = 4,
  parameter int SWEEP_HOLD = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N-1:0]        sel,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef FAULT_INJECT_EN
  input  logic                inj_en,
  input  logic [N-1:0]        inj_bit,
`endif
  input  logic                sweep_start,
  output logic [(1<<N)-1:0]   dout,
  output logic                out_valid,
  output logic                busy,
  output logic                sweep_done,
  output logic                fault,
  output logic [N-1:0]        fault_code
);
  localparam int OUT_W = 1 << N;
  localparam int HW    = $clog2(SWEEP_HOLD + 1);
  localparam logic [OUT_W-1:0] ONE  = OUT_W'(1);
  localparam logic [N-1:0]     LAST = '1;
  localparam logic [HW-1:0]    HOLD = HW'(SWEEP_HOLD);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [N-1:0]     code;
  logic [HW-1:0]    hold_cnt;
  logic [N-1:0]     exp_code;
  logic             exp_en;
  logic [OUT_W-1:0] inj_mask;
  logic             mismatch;

  function automatic logic [OUT_W-1:0] onehot(input logic [N-1:0] c);
    return ONE << c;
  endfunction

`ifdef FAULT_INJECT_EN
  assign inj_mask = inj_en ? (ONE << inj_bit) : '0;
`else
  assign inj_mask = '0;
`endif

  // sweep_start takes priority over a same-cycle input transfer
  assign in_ready = !rst && (state == IDLE) && !sweep_start;

  // exp_code/exp_en track what the last out_valid pulse should have shown
  assign mismatch = out_valid && (dout != (exp_en ? onehot(exp_code) : '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      hold_cnt   <= '0;
      exp_code   <= '0;
      exp_en     <= 1'b0;
      dout       <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      fault      <= 1'b0;
      fault_code <= '0;
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (mismatch && !fault) begin
        fault      <= 1'b1;
        fault_code <= exp_code;
      end
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SWEEP;
            busy       <= 1'b1;
            code       <= '0;
            hold_cnt   <= HW'(1);
            dout       <= onehot('0) | inj_mask;
            out_valid  <= 1'b1;
            exp_code   <= '0;
            exp_en     <= 1'b1;
            fault      <= 1'b0;
            fault_code <= '0;
          end else if (in_valid) begin
            dout      <= (en ? onehot(sel) : '0) | inj_mask;
            out_valid <= 1'b1;
            exp_code  <= sel;
            exp_en    <= en;
          end
        end
        SWEEP: begin
          if (hold_cnt < HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (code == LAST) begin
            state      <= DONE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
            hold_cnt   <= '0;
            code       <= '0;
          end else begin
            code      <= code + 1'b1;
            hold_cnt  <= HW'(1);
            dout      <= onehot(code + 1'b1) | inj_mask;
            out_valid <= 1'b1;
            exp_code  <= code + 1'b1;
            exp_en    <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_nx2n_seq_chk.sv
// Scoreboard bench for dec_nx2n_seq_chk (N=4, SWEEP_HOLD=2): stimulus queues expected dout, monitor pops on out_valid.
module tb_dec_nx2n_seq_chk;
  localparam int N = 4;
  localparam int OUT_W = 16;

  logic             clk = 1'b0;
  logic             rst, en, in_valid, in_ready, sweep_start;
  logic [N-1:0]     sel;
  logic [OUT_W-1:0] dout;
  logic             out_valid, busy, sweep_done, fault;
  logic [N-1:0]     fault_code;
`ifdef FAULT_INJECT_EN
  logic             inj_en;
  logic [N-1:0]     inj_bit;
`endif

  int checks = 0;
  int failures = 0;
  int busy_cycles = 0;
  int done_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];

  dec_nx2n_seq_chk #(.N(N), .SWEEP_HOLD(2)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
`ifdef FAULT_INJECT_EN
    .inj_en(inj_en), .inj_bit(inj_bit),
`endif
    .sweep_start(sweep_start), .dout(dout), .out_valid(out_valid), .busy(busy),
    .sweep_done(sweep_done), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep();
    for (int i = 0; i < OUT_W; i++) exp_q.push_back(OUT_W'(1) << i);
  endtask

  task automatic wait_done(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 10) begin
        sweep_start = 1'b1; in_valid = 1'b1; sel = 4'h7; en = 1'b1;
        #1;
        check({name, "_in_ready_mid"}, in_ready, 1'b0);
        check({name, "_busy_mid"}, busy, 1'b1);
        step();
        sweep_start = 1'b0; in_valid = 1'b0;
      end
      if (done_cnt == 1) begin seen = 1; break; end
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_busy_cycles"}, busy_cycles, 32);
    check({name, "_sweep_done_cleared"}, sweep_done, 1'b0);
    check({name, "_in_ready_after"}, in_ready, 1'b1);
    check({name, "_fault"}, fault, 1'b0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: every out_valid pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got dout 0x%0h expected no pulse at %0t", dout, $time);
        end else begin
          check("dout", dout, exp_q.pop_front());
        end
      end
      if (busy) busy_cycles++;
      if (sweep_done) begin
        done_cnt++;
        check("done_dout_held", dout, 16'h8000);
        check("done_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [15:0] vec_dout [4] = '{16'h0400, 16'h0000, 16'h8000, 16'h0001};
  logic [3:0]  vec_sel  [4] = '{4'hA, 4'h3, 4'hF, 4'h0};
  logic        vec_en   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; sel = '0; in_valid = 1'b0; sweep_start = 1'b0;
`ifdef FAULT_INJECT_EN
    inj_en = 1'b0; inj_bit = '0;
`endif
    step();
    step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_dout", dout, 16'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_fault", fault, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // single transfer, then back-to-back transfers
    for (int i = 0; i < 4; i++) begin
      sel = vec_sel[i]; en = vec_en[i]; in_valid = 1'b1;
      exp_q.push_back(vec_dout[i]);
      step();
      if (i == 0) begin
        in_valid = 1'b0;
        step();
        check("pulse_one_cycle", out_valid, 1'b0);
        check("hold_after_xfer", dout, 16'h0400);
      end
    end
    in_valid = 1'b0; sel = 4'h5; en = 1'b1;
    step(); step();
    check("dout_holds", dout, 16'h0001);
    check("xfer_fault", fault, 1'b0);
    check("xfer_queue_empty", exp_q.size(), 0);

    // sweep, with an ignored sweep_start/in_valid in the middle
    busy_cycles = 0; done_cnt = 0;
    push_sweep();
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    wait_done("sweep1");

    // sweep_start and in_valid in the same cycle: sweep wins
    busy_cycles = 0; done_cnt = 0;
    sweep_start = 1'b1; in_valid = 1'b1; sel = 4'h9; en = 1'b1;
    #1;
    check("start_vs_valid_in_ready", in_ready, 1'b0);
    push_sweep();
    step();
    sweep_start = 1'b0; in_valid = 1'b0;
    wait_done("sweep2");

    // reset mid-sweep: codes 0,1,2 appear, then abort without sweep_done
    done_cnt = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(OUT_W'(1) << i);
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("abort_busy", busy, 1'b0);
    check("abort_dout", dout, 16'h0);
    check("abort_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    step(); step();
    check("abort_no_done", done_cnt, 0);
    check("abort_queue_empty", exp_q.size(), 0);
    check("abort_sweep_done", sweep_done, 1'b0);

`ifdef FAULT_INJECT_EN
    inj_en = 1'b1; inj_bit = 4'd5;
    sel = 4'h2; en = 1'b1; in_valid = 1'b1;
    exp_q.push_back(16'h0024);
    step();
    in_valid = 1'b0; inj_en = 1'b0;
    step();
    check("inj_fault", fault, 1'b1);
    check("inj_fault_code", fault_code, 4'h2);
`endif

    repeat (3) step();
    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
